// File: rtl/aip_crc_pkg.sv
// ---------------------------------------------------------------------------
// aip_crc_pkg
// Shared definitions for the AIP CRC-32 engine: AIP register/port selector
// codes, the ID word, CRC-32 constants, the default FIFO depth and the
// engine FSM state type.
// ---------------------------------------------------------------------------
package aip_crc_pkg;

  // AIP conf_dbus selector codes
  localparam logic [4:0] CONF_DATA_IN  = 5'h00;  // write: push word to FIFO
  localparam logic [4:0] CONF_RESULT   = 5'h01;  // read : last CRC result
  localparam logic [4:0] CONF_INT_CTRL = 5'h1D;  // write: bit0 int enable, bit1 clear
  localparam logic [4:0] CONF_STATUS   = 5'h1E;  // read : status word
  localparam logic [4:0] CONF_ID       = 5'h1F;  // read : block identifier

  localparam logic [31:0] AIP_ID = 32'h0000_1002;

  // CRC-32 (IEEE 802.3), reflected form
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR  = 32'hFFFF_FFFF;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CALC   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage : aip_crc_pkg

// File: rtl/crc32_byte_step.sv
// ---------------------------------------------------------------------------
// crc32_byte_step
// Purely combinational: advances a reflected CRC-32 register by one byte.
//   crc_in  [31:0] : current CRC register
//   byte_in [7:0]  : next message byte
//   crc_out [31:0] : CRC register after absorbing byte_in
// ---------------------------------------------------------------------------
module crc32_byte_step
  import aip_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  always_comb begin
    // NOTE: blocking assignments are intended here -- each loop iteration
    // builds on the previous one, unrolling into an 8-deep XOR network.
    crc_work = crc_in ^ {24'h0, byte_in};
    for (int i = 0; i < 8; i++) begin
      crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY) : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule : crc32_byte_step

// File: rtl/aip_crc32_engine.sv
// ---------------------------------------------------------------------------
// aip_crc32_engine
// AIP-attached CRC-32 accelerator. Words written to DATA_IN are queued in a
// FIFO; a start pulse runs the CRC over every queued word (LSB byte first,
// one byte per clock) and latches the final value into RESULT.
//
// Ports
//   clk        : system clock, rising edge
//   rst_a      : asynchronous active-low reset
//   en_s       : synchronous enable; low freezes all state and ignores strobes
//   data_in    : AIP write data
//   data_out   : AIP read data, registered (valid 1 cycle after read)
//   write      : one-cycle write strobe, qualified by conf_dbus
//   read       : one-cycle read strobe, qualified by conf_dbus
//   start      : one-cycle start pulse
//   conf_dbus  : register/port selector
//   int_req    : level interrupt = done & int_enable
// ---------------------------------------------------------------------------
module aip_crc32_engine
  import aip_crc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en_s,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  write,
  input  logic                  read,
  input  logic                  start,
  input  logic [4:0]            conf_dbus,
  output logic                  int_req
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DATA_WIDTH != 32) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("aip_crc32_engine: DATA_WIDTH must be 32 and FIFO_DEPTH a power of two");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [31:0]             word_q, word_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             crc_q, crc_d;
  logic [31:0]             result_q, result_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic                    int_en_q, int_en_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

  // -------------------------------------------------------------------------
  // Decode and datapath helpers
  // -------------------------------------------------------------------------
  logic        fifo_full, fifo_empty;
  logic        push_req, push, pop;
  logic        int_ctrl_wr;
  logic [7:0]  cur_byte;
  logic [31:0] step_crc;
  logic [31:0] status_word;

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push_req    = en_s && write && (conf_dbus == CONF_DATA_IN);
  // A write with the FIFO full is dropped (and flagged), even if a pop
  // happens in the same cycle.
  assign push        = push_req && !fifo_full;
  assign pop         = en_s && (state_q == ST_LOAD);
  assign int_ctrl_wr = en_s && write && (conf_dbus == CONF_INT_CTRL);
  assign cur_byte    = word_q[{byte_idx_q, 3'b000} +: 8];
  assign status_word = {22'h0, ovf_q, busy_q, done_q, fifo_full, fifo_empty,
                        5'(count_q)};

  crc32_byte_step u_step (
    .crc_in  (crc_q),
    .byte_in (cur_byte),
    .crc_out (step_crc)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    crc_d      = crc_q;
    result_d   = result_q;
    done_d     = done_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    int_en_d   = int_en_q;
    data_out_d = data_out_q;

    // FIFO bookkeeping
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_req && fifo_full) ovf_d = 1'b1;

    // Interrupt control; a clear is evaluated before the FSM so that a
    // start or a finishing run in the same cycle overrides it.
    if (int_ctrl_wr) begin
      int_en_d = data_in[0];
      if (data_in[1]) begin
        done_d = 1'b0;
        ovf_d  = 1'b0;
      end
    end

    if (en_s) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            // The empty run also reloads CRC_INIT so its result is exactly 0.
            crc_d   = CRC_INIT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = fifo_empty ? ST_FINISH : ST_LOAD;
          end
        end
        ST_LOAD: begin
          word_d     = fifo_mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          state_d    = ST_CALC;
        end
        ST_CALC: begin
          crc_d      = step_crc;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Words pushed during the run join it if present at this boundary.
            state_d = fifo_empty ? ST_FINISH : ST_LOAD;
          end
        end
        ST_FINISH: begin
          result_d = crc_q ^ CRC_XOR;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (read) begin
        unique case (conf_dbus)
          CONF_RESULT: data_out_d = result_q;
          CONF_STATUS: data_out_d = status_word;
          CONF_ID:     data_out_d = AIP_ID;
          default:     data_out_d = '0;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      byte_idx_q <= 2'd0;
      crc_q      <= CRC_INIT;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      int_en_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      crc_q      <= crc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      int_en_q   <= int_en_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign int_req  = done_q & int_en_q;

endmodule : aip_crc32_engine

// File: tb/tb_aip_crc32_engine.sv
// ---------------------------------------------------------------------------
// tb_aip_crc32_engine
// Directed bench for aip_crc32_engine. Reads push their expected value into
// a scoreboard queue; a monitor pops and compares when read data appears.
// ---------------------------------------------------------------------------
module tb_aip_crc32_engine;

  localparam logic [4:0] C_DATA = 5'h00;
  localparam logic [4:0] C_RES  = 5'h01;
  localparam logic [4:0] C_INT  = 5'h1D;
  localparam logic [4:0] C_STAT = 5'h1E;
  localparam logic [4:0] C_ID   = 5'h1F;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        en_s = 1'b1;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  conf_dbus = '0;
  logic        int_req;

  aip_crc32_engine dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .read      (read),
    .start     (start),
    .conf_dbus (conf_dbus),
    .int_req   (int_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          e0 = 0;
  logic [31:0] b_last = '0;
  logic        b_done = 1'b0;
  logic        b_ovf = 1'b0;
  logic        b_inten = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a qualified read sampled at an edge shows up on data_out after it.
  initial forever begin
    logic sampled;
    @(posedge clk);
    sampled = read && en_s && rst_a;
    if (sampled) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check("unexpected_read", data_out, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, data_out, e.exp);
      end
    end
  end

  function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                              input logic done, input logic [4:0] cnt);
    return {22'h0, ovf, busy, done, (cnt == 5'd16), (cnt == 5'd0), cnt};
  endfunction

  // Bit-serial reference CRC-32 (reflected, init/xorout all ones).
  function automatic logic [31:0] crc_model(input logic [31:0] w[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int b = 0; b < 4; b++) begin
        c ^= {24'h0, w[i][8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // All tasks start and end 1 ns after a rising edge.
  task automatic do_write(input logic [4:0] code, input logic [31:0] d);
    write = 1'b1; conf_dbus = code; data_in = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] code, input logic [31:0] exp,
                         input string name);
    exp_t e;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
    b_last = exp;
    read = 1'b1; conf_dbus = code;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  // Checks done rises exactly at edge e0+k and RESULT afterwards.
  task automatic finish_run(input int k, input logic [31:0] exp_res, input string tag);
    check({tag, "_sched"}, 32'(cyc <= e0 + k - 1), 32'd1);
    while (cyc < e0 + k - 1) begin
      @(posedge clk); #1;
    end
    do_read(C_STAT, status_word(b_ovf, 1'b1, 1'b0, 5'd0), {tag, "_pre_done"});
    check({tag, "_int_req"}, 32'(int_req), 32'(b_inten));
    do_read(C_STAT, status_word(b_ovf, 1'b0, 1'b1, 5'd0), {tag, "_done"});
    do_read(C_RES, exp_res, {tag, "_result"});
    b_done = 1'b1;
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] wq16[$];

    #12;
    check("rst_data_out", data_out, 32'h0);
    check("rst_int_req", 32'(int_req), 32'h0);
    #5 rst_a = 1'b1;
    @(posedge clk); #1;

    // Reset state and register map
    do_read(C_STAT, 32'h0000_0020, "rst_status");
    do_read(C_RES, 32'h0, "rst_result");
    do_read(C_ID, 32'h0000_1002, "id");
    do_read(5'h05, 32'h0, "unmapped");

    // "1234" with interrupt disabled
    do_write(C_DATA, 32'h3433_3231);
    start_run();
    finish_run(6, 32'h9BE3_E0A3, "crc_1234");

    // Write to read-only code is ignored
    do_write(C_RES, 32'hDEAD_BEEF);
    do_read(C_RES, 32'h9BE3_E0A3, "ro_write");

    // Four zero bytes with interrupt enabled, then clear
    do_write(C_INT, 32'h3);
    b_inten = 1'b1; b_done = 1'b0;
    do_write(C_DATA, 32'h0);
    start_run();
    finish_run(6, 32'h2144_DF1C, "crc_zero");
    check("int_before_clr", 32'(int_req), 32'h1);
    do_write(C_INT, 32'h3);
    check("int_after_clr", 32'(int_req), 32'h0);
    b_done = 1'b0;

    // Empty run
    start_run();
    finish_run(1, 32'h0, "empty");

    // Word pushed during the run joins it; RESULT read while busy is old
    do_write(C_DATA, 32'h3433_3231);
    start_run();
    do_write(C_DATA, 32'h3837_3635);
    do_read(C_RES, 32'h0, "busy_result");
    wq = '{32'h3433_3231, 32'h3837_3635};
    finish_run(11, crc_model(wq), "two_words");

    // Overflow: 17 words, 16 kept
    wq16.delete();
    for (int i = 0; i < 17; i++) begin
      logic [31:0] w;
      w = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      do_write(C_DATA, w);
      if (i < 16) wq16.push_back(w);
    end
    b_ovf = 1'b1;
    do_read(C_STAT, status_word(1'b1, 1'b0, b_done, 5'd16), "full_status");
    start_run();
    finish_run(81, crc_model(wq16), "sixteen");
    do_write(C_INT, 32'h2);
    b_ovf = 1'b0; b_done = 1'b0; b_inten = 1'b0;
    do_read(C_STAT, 32'h0000_0020, "ovf_cleared");

    // en_s low: strobes ignored, state frozen
    en_s = 1'b0;
    start = 1'b1; write = 1'b1; conf_dbus = C_DATA; data_in = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0; write = 1'b0;
    read = 1'b1; conf_dbus = C_ID;
    @(posedge clk); #1;
    read = 1'b0;
    check("en_low_data_out", data_out, b_last);
    en_s = 1'b1;
    do_read(C_STAT, 32'h0000_0020, "en_low_status");

    // Reset mid-run
    do_read(C_ID, 32'h0000_1002, "id_pre_rst");
    do_write(C_DATA, 32'h1234_5678);
    do_write(C_DATA, 32'h9ABC_DEF0);
    start_run();
    while (cyc < e0 + 3) begin
      @(posedge clk); #1;
    end
    rst_a = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_int_req", 32'(int_req), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b1;
    do_read(C_STAT, 32'h0000_0020, "midrst_status");
    do_write(C_DATA, 32'h3433_3231);
    start_run();
    finish_run(6, 32'h9BE3_E0A3, "after_rst");

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_aip_crc32_engine

// File: doc/aip_crc32_engine.md
AIP_CRC32_ENGINE -- requirements
Module: aip_crc32_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_a.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the AIP data bus width; only 32 is supported.
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL set the input FIFO depth; it SHALL be a power of two.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst_a  in  1  async active-low reset.
REQ-006 en_s  in  1  synchronous enable; when low the FSM holds state and write/read/start are ignored.
REQ-007 data_in  in  32  AIP write data from the controller slave port.
REQ-008 data_out  out  32  AIP read data, registered.
REQ-009 write  in  1  one-cycle write strobe, qualified by conf_dbus.
REQ-010 read  in  1  one-cycle read strobe, qualified by conf_dbus.
REQ-011 start  in  1  one-cycle start pulse.
REQ-012 conf_dbus  in  5  register/port selector.
REQ-013 int_req  out  1  level interrupt to the controller's i_int_IP bit.

Function
REQ-014 conf_dbus codes SHALL be:
- 0x00 DATA_IN (write): push to FIFO.
- 0x01 RESULT (read).
- 0x1D INT_CTRL (write): bit0 int enable, bit1 write-1-to-clear done/overflow.
- 0x1E STATUS (read): {22'b0, overflow, busy, done, full, empty, count[4:0]}.
- 0x1F ID (read): 32'h0000_1002.
REQ-015 A read strobe SHALL load data_out on the next edge, so data is valid 1 cycle after read; unmapped codes SHALL return 0; write strobes to read-only codes SHALL be ignored.
REQ-016 A DATA_IN write with the FIFO full SHALL drop the word and set sticky overflow.
REQ-017 A push and pop in the same cycle SHALL both occur, leaving count unchanged.
REQ-018 Writes to DATA_IN while busy SHALL be accepted and processed in the same run if present at a word boundary.
REQ-019 The CRC SHALL be CRC-32 with reflected polynomial 0xEDB88320, init 0xFFFFFFFF and final XOR 0xFFFFFFFF; each word SHALL be consumed LSB byte first, one byte per cycle.
REQ-020 The FSM SHALL have the states IDLE, LOAD, CALC and FINISH.
- IDLE: on start with FIFO non-empty, go to LOAD, set crc=0xFFFFFFFF, busy=1 and clear done; with FIFO empty, go to FINISH.
- LOAD: pop one word and go to CALC with byte_idx=0.
- CALC: 4 cycles; after byte 3, go to LOAD if count>0, else FINISH.
- FINISH: result=~crc (0x00000000 for an empty run), done=1, busy=0, then IDLE.
REQ-021 Latency: start sampled at edge E0 with N words queued SHALL give done=1 and RESULT valid at edge E0+5N+1; an empty run SHALL complete at E0+1.
REQ-022 start while busy SHALL be ignored.
REQ-023 RESULT read while busy SHALL return the previous result.
REQ-024 int_req SHALL equal done AND int_enable.
REQ-025 If a clear and a start occur in the same cycle, start SHALL win and done SHALL be 0.

Reset
REQ-026 Reset SHALL set:
- data_out=0, int_req=0, result=0, crc=0xFFFFFFFF.
- FIFO empty (pointers 0), count=0.
- overflow=0, done=0, busy=0, int_enable=0, state=IDLE.
REQ-027 Reset asserted mid-run SHALL abort immediately; FIFO contents SHALL be discarded.

Structure
REQ-028 Package aip_crc_pkg SHALL hold the conf codes, the ID constant, polynomial/init/xor constants, FIFO_DEPTH default and the FSM state enum.
REQ-029 One combinational sub-module, crc32_byte_step (crc_in[31:0], byte[7:0] -> crc_out[31:0]), SHALL be instantiated once.

Verification
REQ-030 Write 0x34333231, start -> done at E0+6, int_req=0 (enable off), RESULT=0x9BE3E0A3.
REQ-031 Enable int, write 0x00000000, start -> int_req=1 at E0+6, RESULT=0x2144DF1C; INT_CTRL write 0x3 -> int_req=0 next cycle.
REQ-032 Start with FIFO empty -> done at E0+1, RESULT=0x00000000.
REQ-033 Write 17 words -> STATUS full=1, count=16, overflow=1; start -> done at E0+81; INT_CTRL 0x2 -> overflow=0.
REQ-034 Write 2 words, start; at E0+3 assert rst_a low -> all outputs 0 and STATUS empty=1; a new run with 0x34333231 gives 0x9BE3E0A3.
REQ-035 Read ID -> 0x00001002 one cycle after read; start with en_s=0 -> no state change.
